// File: rtl/step_input_pkg.sv
// Shared definitions for the step input conditioner.
//   - state_e: debounce / hold / auto-repeat FSM states
//   - default timing constants for a 50 MHz board clock
package step_input_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_e;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 1000;  // 1 ms
  localparam int DEF_HOLD_CYCLES     = CLK_HZ / 2;     // 0.5 s
  localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 10;    // 0.1 s
  localparam int DEF_CNT_W           = 25;

  // Levels that count as "button is down" from the debouncer's point of view.
  function automatic logic level_of(input state_e st);
    return (st == HELD) || (st == REPEAT) || (st == DB_RELEASE);
  endfunction

endpackage

// File: rtl/step_input_conditioner_sync_chain.sv
// sync_chain: STAGES-deep flip-flop synchroniser for an asynchronous bit.
// Ports:
//   clk   - destination clock
//   rst_n - async active-low reset, clears every stage
//   d_i   - asynchronous input
//   q_o   - synchronised output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/step_input_conditioner.sv
// step_input_conditioner: turns a raw bouncing pushbutton into a single-cycle
// step pulse `s`, with optional auto-repeat while the button is held.
// Ports:
//   clk         - system clock
//   rst_n       - async active-low reset
//   btn_raw     - raw asynchronous active-high pushbutton
//   repeat_en   - enables auto-repeat pulses while held
//   s           - one-cycle step pulse (registered)
//   btn_level   - debounced button level (registered)
//   press_count - wrapping count of emitted s pulses (registered)
module step_input_conditioner
  import step_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       repeat_en,
  output logic       s,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic btn_sync;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (btn_raw),
    .q_o  (btn_sync)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             lvl_q, lvl_d;
  logic [7:0]       pcnt_q, pcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      lvl_q   <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      lvl_q   <= lvl_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // One shared counter; every state change below clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    s_d     = 1'b0;
    pcnt_d  = pcnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_sync) state_d = DB_PRESS;
      end

      DB_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          s_d     = 1'b1;
          pcnt_d  = pcnt_q + 8'd1;
        end
      end

      HELD: begin
        if (!btn_sync) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          if (repeat_en) begin
            state_d = REPEAT;
            cnt_d   = '0;
            s_d     = 1'b1;
            pcnt_d  = pcnt_q + 8'd1;
          end else begin
            // Park at the terminal count so enabling repeat later
            // fires on the very next edge.
            cnt_d = cnt_q;
          end
        end
      end

      REPEAT: begin
        if (!btn_sync) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d  = '0;
          s_d    = 1'b1;
          pcnt_d = pcnt_q + 8'd1;
        end
      end

      DB_RELEASE: begin
        if (btn_sync) begin
          // Release glitch: back to HELD with a fresh hold timer, no pulse.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level is registered alongside the state it belongs to.
    lvl_d = level_of(state_d);
  end

  assign s           = s_q;
  assign btn_level   = lvl_q;
  assign press_count = pcnt_q;

endmodule

// File: tb/tb_step_input_conditioner.sv
// Directed, table-driven bench for step_input_conditioner using
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
// Edge numbering: edge 0 is the first clock edge sampling btn_raw=1; values
// checked after step() are those registered on that edge.
module tb_step_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       repeat_en = 1'b0;
  logic       s;
  logic       btn_level;
  logic [7:0] press_count;

  int n_chk = 0;
  int n_fail = 0;

  step_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .s          (s),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       ren;
    logic       exp_s;
    logic       exp_lvl;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, e, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int e, input logic es, input logic el, input logic [7:0] ec);
    chk({tag, ".s"}, e, 32'(s), 32'(es));
    chk({tag, ".level"}, e, 32'(btn_level), 32'(el));
    chk({tag, ".count"}, e, 32'(press_count), 32'(ec));
  endtask

  // Leaves rst_n released 1 ns after an edge, so the next edge is edge 0.
  task automatic do_reset();
    btn_raw   = 1'b0;
    repeat_en = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_cnt;
    int pulses;
    logic prev_s;
    logic es;

    // Clean press table: held 20 edges, pulse after edge 6 only.
    for (int i = 0; i < 20; i++)
      tbl[i] = '{1'b1, 1'b0, (i == 6), (i >= 6), ((i >= 6) ? 8'd1 : 8'd0)};

    // ---- reset state ----
    rst_n = 1'b0;
    #2;
    chk_out("reset", -1, 1'b0, 1'b0, 8'd0);
    do_reset();

    // ---- clean press (table) ----
    for (int i = 0; i < 20; i++) begin
      btn_raw   = tbl[i].btn;
      repeat_en = tbl[i].ren;
      step();
      chk_out("clean", i, tbl[i].exp_s, tbl[i].exp_lvl, tbl[i].exp_cnt);
    end

    // ---- bounce rejection ----
    do_reset();
    begin
      logic [5:0] pat;
      pat = 6'b011011;  // LSB first: 1,1,0,1,1,0
      for (int i = 0; i < 14; i++) begin
        btn_raw = (i < 6) ? pat[i] : 1'b0;
        step();
        chk_out("bounce", i, 1'b0, 1'b0, 8'd0);
      end
    end

    // ---- auto-repeat ----
    do_reset();
    repeat_en = 1'b1;
    btn_raw   = 1'b1;
    exp_cnt = 0;
    prev_s  = 1'b0;
    for (int e = 0; e <= 46; e++) begin
      step();
      es = (e == 6) || (e >= 16 && ((e - 16) % 3) == 0);
      if (es) exp_cnt++;
      chk_out("repeat", e, es, (e >= 6), 8'(exp_cnt));
      chk("repeat.no_b2b", e, 32'(prev_s & s), 32'd0);
      prev_s = s;
    end
    chk("repeat.total", 46, 32'(press_count), 32'd12);

    // ---- release debounce with a one-cycle glitch ----
    do_reset();
    for (int e = 0; e <= 24; e++) begin
      btn_raw = (e <= 9) || (e == 12);
      step();
      chk_out("release", e, (e == 6), (e >= 6 && e <= 18), ((e >= 6) ? 8'd1 : 8'd0));
    end

    // ---- async reset mid-repeat, then a fresh press while held ----
    do_reset();
    repeat_en = 1'b1;
    btn_raw   = 1'b1;
    for (int e = 0; e <= 20; e++) step();
    chk("midrep.pre_level", 20, 32'(btn_level), 32'd1);
    chk("midrep.pre_count", 20, 32'(press_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_out("midrep.async", 20, 1'b0, 1'b0, 8'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      chk_out("midrep.after", e, (e == 6), (e >= 6), ((e >= 6) ? 8'd1 : 8'd0));
    end

    // ---- wrap: 256 clean presses ----
    do_reset();
    for (int k = 0; k < 256; k++) begin
      pulses = 0;
      btn_raw = 1'b1;
      for (int c = 0; c < 8; c++) begin step(); if (s) pulses++; end
      btn_raw = 1'b0;
      for (int c = 0; c < 8; c++) begin step(); if (s) pulses++; end
      if (pulses != 1 || press_count != 8'((k + 1) % 256) || k == 255 || (k % 32) == 0) begin
        chk("wrap.pulses", k, 32'(pulses), 32'd1);
        chk("wrap.count", k, 32'(press_count), 32'((k + 1) % 256));
      end
    end
    chk("wrap.final", 256, 32'(press_count), 32'd0);
    chk("wrap.level", 256, 32'(btn_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/step_input_conditioner.md
Name: step_input_conditioner

Overview:
- Produces the single-bit step input `s` consumed by the 4-bit next-state logic of the control FSM, from a raw, bouncing, asynchronous pushbutton.
- Synchronises the button, debounces it with a counter-based FSM, and emits exactly one one-cycle `s` pulse per accepted press.
- Optional auto-repeat: while the button is held, further `s` pulses follow at a fixed period.
- Also exports the debounced level and a wrapping count of emitted pulses for display/debug.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the btn_raw synchroniser chain (≥2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (≥2).
- HOLD_CYCLES, 25000000, cycles held in HELD before the first auto-repeat pulse (≥2).
- REPEAT_CYCLES, 5000000, period between auto-repeat pulses (≥2).
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- btn_raw, input, 1, raw pushbutton, asynchronous, active-high, bouncing.
- repeat_en, input, 1, synchronous enable for auto-repeat.
- s, output, 1, one-cycle step pulse to next-state logic.
- btn_level, output, 1, debounced button level.
- press_count, output, 8, count of s pulses, wraps 255→0.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser chain, counter and press_count cleared to 0; state=IDLE.
  - Outputs on reset: s=0, btn_level=0, press_count=0.
  - Takes effect immediately, including mid-debounce or mid-repeat.
- Synchroniser: btn_sync = last stage of the SYNC_STAGES chain. FSM and counter see only btn_sync.
- All outputs are registered.
- States (one counter, cleared on every state entry):
  - IDLE (btn_level=0): btn_sync=1 → DB_PRESS.
  - DB_PRESS (btn_level=0):
    - btn_sync=0 → IDLE (bounce rejected, no pulse).
    - btn_sync=1 and cnt==DEBOUNCE_CYCLES-1 → HELD, with s=1 and press_count+1 registered on that edge.
    - Otherwise cnt+1.
  - HELD (btn_level=1):
    - btn_sync=0 → DB_RELEASE.
    - repeat_en=1 and cnt==HOLD_CYCLES-1 → REPEAT, with s pulse.
    - Otherwise cnt+1. When repeat_en=0, cnt saturates at HOLD_CYCLES-1 and emits no pulses.
  - REPEAT (btn_level=1):
    - btn_sync=0 → DB_RELEASE.
    - repeat_en=0 → HELD (cnt cleared).
    - cnt==REPEAT_CYCLES-1 → s pulse, cnt=0, stay in REPEAT.
    - Otherwise cnt+1.
  - DB_RELEASE (btn_level=1):
    - btn_sync=1 → HELD (cnt cleared; release glitch restarts the hold timer; no pulse).
    - btn_sync=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE, btn_level=0.
    - Otherwise cnt+1.
- btn_level is 1 in HELD, REPEAT and DB_RELEASE; 0 otherwise. It is registered with the state.
- Latency: count the first edge sampling btn_raw=1 as edge 0 and hold btn_raw stable. Then s=1 for exactly the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- s is never high on two consecutive cycles.
- s is high only on the first-press transition or on a repeat event.
- press_count increments by exactly 1 per s pulse; it is modulo 256.
- Reset release while the button is held: the synchroniser restarts from 0, a full debounce occurs, and then one fresh pulse.
- Unknown/unreachable state encodings return to IDLE on the next edge.

Decomposition:
- Shared package `step_input_pkg`:
  - State enum: IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE.
  - Default timing constants for a 50 MHz board clock: 1 ms debounce, 0.5 s hold, 0.1 s repeat.
- One natural sub-module: `sync_chain`, a parameterised SYNC_STAGES flip-flop synchroniser with async active-low reset.
- FSM, counter and press_count live in the top.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Clean press: btn_raw 0→1 held 20 cycles, repeat_en=0 → s=1 only in the cycle after edge 6; btn_level rises on the same edge; press_count=1. No further pulses.
- Bounce rejection: btn_raw pattern 1,1,0,1,1,0 then 0 → s never asserts; btn_level stays 0; press_count=0.
- Auto-repeat: repeat_en=1, button held 40 cycles after acceptance → first pulse at acceptance, second 10 cycles later, then every 3 cycles. press_count equals total pulses; no back-to-back s.
- Release debounce: accepted press, then btn_raw 0 for 2 cycles, 1 for 1 cycle, then 0 → no pulse. btn_level falls exactly 4 cycles after btn_sync goes steady 0.
- Reset mid-repeat: rst_n low asynchronously during REPEAT → s=0, btn_level=0, press_count=0 immediately. Button still held after release → one pulse 6 edges after the first sampling edge.
- Wrap: 256 clean presses → press_count returns to 0 after the 256th pulse.
